// File: rtl/uart_resp_tx.sv
// Word-oriented UART transmitter: buffers 32-bit responses in a small FIFO and sends them MSB byte first.
// Optional even parity bit per byte when UART_TX_PARITY_EN is defined (8E1); default build is 8N1.
module uart_resp_tx #(
  parameter int SCYCLE   = 50_000_000,
  parameter int BAUDRATE = 9600,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        write_en,
  output logic        ready,
  output logic        TX,
  output logic        TXBUSY,
  output logic        done
);

  localparam int CPB = SCYCLE / BAUDRATE;
  localparam int BW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [BW-1:0] C_LAST = BW'(CPB - 1);
  localparam logic [BW-1:0] C_PRE  = BW'(CPB - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t        r_state, w_state_next;
  logic [BW-1:0] r_baud, w_baud_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [1:0]    r_byte, w_byte_next;
  logic [31:0]   r_shift, w_shift_next;
  logic          r_tx, w_tx_next;
  logic          r_done, w_done_next;
  logic          r_busy;
  logic          r_chain, w_chain_next;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_count_next;
  logic          w_push, w_pop;
  logic [31:0]   w_rd_data;
  logic [7:0]    w_cur_byte;
  logic [2:0]    w_bit_inc;

  assign ready        = (r_count < (AW+1)'(DEPTH));
  assign w_push       = write_en & ready;
  assign w_rd_data    = r_mem[r_rd_ptr];
  assign w_cur_byte   = r_shift[31:24];
  assign w_bit_inc    = r_bit + 3'd1;
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign TX     = r_tx;
  assign TXBUSY = r_busy;
  assign done   = r_done;

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud + BW'(1);
    w_bit_next   = r_bit;
    w_byte_next  = r_byte;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_done_next  = 1'b0;
    w_chain_next = r_chain;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (r_count != '0) begin
          w_state_next = S_LOAD;
          w_chain_next = 1'b0;
        end
      end
      S_LOAD: begin
        // A chained LOAD is the last clock of the previous word's stop bit,
        // so the done pulse for that word lands on this exit edge.
        w_pop        = 1'b1;
        w_shift_next = w_rd_data;
        w_byte_next  = '0;
        w_bit_next   = '0;
        w_baud_next  = '0;
        w_tx_next    = 1'b0;
        w_done_next  = r_chain;
        w_state_next = S_START;
      end
      S_START: begin
        if (r_baud == C_LAST) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_tx_next    = w_cur_byte[0];
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (r_baud == C_LAST) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_next    = ^w_cur_byte;
            w_state_next = S_PARITY;
`else
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = w_bit_inc;
            w_tx_next  = w_cur_byte[w_bit_inc];
          end
        end
      end
      S_PARITY: begin
        if (r_baud == C_LAST) begin
          w_baud_next  = '0;
          w_tx_next    = 1'b1;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_byte == 2'd3) begin
          if (r_baud == C_PRE && r_count != '0) begin
            w_baud_next  = '0;
            w_chain_next = 1'b1;
            w_state_next = S_LOAD;
          end else if (r_baud == C_LAST) begin
            w_baud_next  = '0;
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (r_baud == C_LAST) begin
          w_baud_next  = '0;
          w_byte_next  = r_byte + 2'd1;
          w_shift_next = {r_shift[23:0], 8'h00};
          w_tx_next    = 1'b0;
          w_state_next = S_START;
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_chain  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_byte  <= w_byte_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
      r_busy  <= (w_state_next != S_IDLE) || (w_count_next != '0);
      r_chain <= w_chain_next;
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= data_in;
  end

endmodule
